// File: rtl/countdown_timer.sv
// Programmable down-counting timer: prescaled ticks, one-shot or periodic reload,
// single-cycle expiry pulse and busy/done status.
//
// state | meaning
// IDLE  | stopped; count holds its last value, load writes count directly
// RUN   | counting down one step per prescaled tick
// DONE  | one-shot finished (or started with N==0), count is 0 unless reloaded

module countdown_timer #(
  parameter int BITS     = 8,
  parameter int PRE_BITS = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [BITS-1:0]     load_value,
  input  logic [PRE_BITS-1:0] prescale,
  input  logic                periodic,
  input  logic                start,
  input  logic                stop,
  output logic [BITS-1:0]     count,
  output logic                busy,
  output logic                done,
  output logic                expired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [BITS-1:0]     count_nxt;
  logic [BITS-1:0]     reload_reg, reload_nxt;
  logic [BITS-1:0]     start_value;
  logic [PRE_BITS-1:0] pre_cnt, pre_cnt_nxt;
  logic [PRE_BITS-1:0] pre_lat, pre_lat_nxt;
  logic                per_lat, per_lat_nxt;
  logic                expired_nxt;
  logic                tick;

  // A load on the same edge as start must feed the new value straight into the count.
  assign start_value = load ? load_value : reload_reg;
  assign tick        = (pre_cnt == pre_lat);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      pre_cnt    <= '0;
      pre_lat    <= '0;
      per_lat    <= 1'b0;
      expired    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      pre_cnt    <= pre_cnt_nxt;
      pre_lat    <= pre_lat_nxt;
      per_lat    <= per_lat_nxt;
      expired    <= expired_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    reload_nxt  = load ? load_value : reload_reg;
    pre_cnt_nxt = pre_cnt;
    pre_lat_nxt = pre_lat;
    per_lat_nxt = per_lat;
    expired_nxt = 1'b0;

    if (load && state != RUN) begin
      count_nxt = load_value;
    end

    if (stop) begin
      if (state != IDLE) begin
        state_nxt   = IDLE;
        pre_cnt_nxt = '0;
      end
    end else if (start) begin
      count_nxt   = start_value;
      pre_cnt_nxt = '0;
      pre_lat_nxt = prescale;
      per_lat_nxt = periodic;
      if (start_value == '0) begin
        state_nxt   = DONE;
        expired_nxt = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else if (state == RUN) begin
      if (tick) begin
        pre_cnt_nxt = '0;
        if (count > BITS'(1)) begin
          count_nxt = count - BITS'(1);
        end else begin
          // Final tick: periodic reloads from the register without ever showing 0.
          expired_nxt = 1'b1;
          if (per_lat) begin
            count_nxt = reload_reg;
          end else begin
            count_nxt = '0;
            state_nxt = DONE;
          end
        end
      end else begin
        pre_cnt_nxt = pre_cnt + PRE_BITS'(1);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, directed multi-cycle
// sequences and random stimulus against an elapsed-time reference model.

module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] load_value;
  logic [3:0] prescale;
  logic       periodic;
  logic       start;
  logic       stop;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       expired;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.BITS(8), .PRE_BITS(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .prescale   (prescale),
    .periodic   (periodic),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .expired    (expired)
  );

  always #5 clock = ~clock;

  // Reference model: time since start (or last periodic reload) in clocks; the
  // displayed count is derived from it by division rather than stepped.
  int m_reload, m_idle, m_nrun, m_e, m_p;
  bit m_per, m_run, m_done, m_exp;

  function automatic void model_reset();
    m_reload = 0; m_idle = 0; m_nrun = 0; m_e = 0; m_p = 0;
    m_per = 0; m_run = 0; m_done = 0; m_exp = 0;
  endfunction

  function automatic int m_cur();
    return m_run ? (m_nrun - m_e / (m_p + 1)) : m_idle;
  endfunction

  function automatic void model_step(bit ld, int lv, int ps, bit per, bit st, bit sp);
    int new_reload;
    int n;
    new_reload = ld ? lv : m_reload;
    n          = ld ? lv : m_reload;
    m_exp      = 0;
    if (sp) begin
      if (m_run) begin
        m_idle = m_cur();
        m_run  = 0;
      end else begin
        m_done = 0;
        if (ld) m_idle = lv;
      end
    end else if (st) begin
      m_p = ps; m_per = per;
      if (n == 0) begin
        m_run = 0; m_done = 1; m_idle = 0; m_exp = 1;
      end else begin
        m_run = 1; m_done = 0; m_nrun = n; m_e = 0;
      end
    end else if (m_run) begin
      m_e++;
      if (m_e == m_nrun * (m_p + 1)) begin
        m_exp = 1;
        if (m_per) begin
          m_nrun = m_reload;
          m_e    = 0;
        end else begin
          m_run = 0; m_done = 1; m_idle = 0;
        end
      end
    end else if (ld) begin
      m_idle = lv;
    end
    m_reload = new_reload;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare 1 ns later.
  task automatic cyc(input logic ld, input logic [7:0] lv, input logic [3:0] ps,
                     input logic per, input logic st, input logic sp);
    load = ld; load_value = lv; prescale = ps; periodic = per; start = st; stop = sp;
    @(posedge clock);
    model_step(ld, int'(lv), int'(ps), per, st, sp);
    #1;
    chk("count", 32'(count), 32'(m_cur()));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("expired", 32'(expired), 32'(m_exp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic [3:0] ps;
    logic       per;
    logic       st;
    logic       sp;
    logic [7:0] e_count;
    logic       e_busy;
    logic       e_done;
    logic       e_exp;
  } vec_t;

  vec_t tbl[$];
  int   first;
  int   q[$];
  int   exp_per[7] = '{4, 8, 12, 16, 18, 20, 22};

  initial begin
    //         ld lv  ps per st sp   cnt busy done exp
    tbl.push_back('{1, 5, 0, 0, 1, 0,  5, 1, 0, 0});  // one-shot N=5 P=0
    tbl.push_back('{0, 0, 0, 0, 0, 0,  4, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 0, 0, 0});  // stop in DONE -> IDLE
    tbl.push_back('{1, 0, 0, 1, 1, 0,  0, 0, 1, 1});  // start N=0
    tbl.push_back('{0, 0, 0, 0, 0, 0,  0, 0, 1, 0});
    tbl.push_back('{1, 4, 0, 0, 1, 0,  4, 1, 0, 0});  // stop at count 2
    tbl.push_back('{0, 0, 0, 0, 0, 0,  3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  2, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1,  2, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  2, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0,  4, 1, 0, 0});  // start from reload reg
    tbl.push_back('{0, 0, 0, 0, 0, 0,  3, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1,  3, 0, 0, 0});  // stop beats start
    tbl.push_back('{0, 0, 0, 0, 0, 0,  3, 0, 0, 0});

    reset_n = 1'b0;
    load = 0; load_value = 0; prescale = 0; periodic = 0; start = 0; stop = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_expired", 32'(expired), 32'd0);
    reset_n = 1'b1;
    idle(2);

    foreach (tbl[i]) begin
      cyc(tbl[i].ld, tbl[i].lv, tbl[i].ps, tbl[i].per, tbl[i].st, tbl[i].sp);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_expired", i), 32'(expired), 32'(tbl[i].e_exp));
    end

    // Prescale: N=3, P=2 expires 9 clocks after the start edge.
    cyc(1, 8'd3, 4'd2, 0, 1, 0);
    first = -1;
    for (int i = 1; i <= 14; i++) begin
      cyc(0, 8'd0, 4'd0, 0, 0, 0);
      if (expired && first < 0) first = i;
    end
    chk("pre_expiry_cycle", 32'(first), 32'd9);

    // Periodic N=4, then load 2 mid-run: period shortens after next expiry.
    cyc(1, 8'd4, 4'd0, 1, 1, 0);
    q.delete();
    for (int i = 1; i <= 22; i++) begin
      cyc(i == 13, 8'd2, 4'd5, 0, 0, 0);
      if (expired) q.push_back(i);
    end
    chk("per_n_expiries", 32'(q.size()), 32'd7);
    for (int k = 0; k < 7 && k < q.size(); k++)
      chk($sformatf("per_expiry%0d", k), 32'(q[k]), 32'(exp_per[k]));
    cyc(0, 8'd0, 4'd0, 0, 0, 1);

    // Restart at count 2 (N=6): timing measured from the restart edge.
    cyc(1, 8'd6, 4'd0, 0, 1, 0);
    idle(4);
    chk("rs_count_before", 32'(count), 32'd2);
    cyc(0, 8'd0, 4'd0, 0, 1, 0);
    chk("rs_count_after", 32'(count), 32'd6);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 8'd0, 4'd0, 0, 0, 0);
      if (expired && first < 0) first = i;
    end
    chk("rs_expiry_cycle", 32'(first), 32'd6);

    // Periodic N=1, P=0: expired held high continuously.
    cyc(1, 8'd1, 4'd0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'd0, 4'd0, 0, 0, 0);
      chk("n1_expired", 32'(expired), 32'd1);
      chk("n1_count", 32'(count), 32'd1);
    end
    cyc(0, 8'd0, 4'd0, 0, 0, 1);

    // Asynchronous reset mid-run.
    cyc(1, 8'd5, 4'd0, 0, 1, 0);
    idle(2);
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_expired", 32'(expired), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(4);

    // Random stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 5) == 0, 8'($urandom_range(1, 6)), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
